dma_mem_arbiter: RTL and testbench
==================================

// Module: dma_mem_arbiter
// PURPOSE
//  Word-copy DMA engine plus two-master arbiter in front of the single-port DataMem.
//  The CPU datapath (lw/sw path) and the DMA engine share one DataMem port through this block.
//  The CPU has priority. The DMA uses idle memory cycles and gets a forced slot after STARVE_LIMIT denials.
//  It sits between the CPU memory-stage signals and DataMem (read/write/address/wData/data).
// PARAMETERS
//  ADDR_W        32  byte-address width, same as DataMem address
//  LEN_W         16  transfer length width, in 32-bit words
//  STARVE_LIMIT  4   consecutive denied DMA cycles before the DMA preempts the CPU for one cycle (>=1)
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  cpu_read     in   1       CPU memory read request (MemRead)
//  cpu_write    in   1       CPU memory write request (MemWrite)
//  cpu_addr     in   ADDR_W  CPU byte address
//  cpu_wdata    in   32      CPU store data
//  cpu_rdata    out  32      mem_rdata passed through to the CPU
//  cpu_stall    out  1       CPU request not served this cycle; CPU holds PC and request
//  cfg_src      in   ADDR_W  source byte address, sampled on cfg_start
//  cfg_dst      in   ADDR_W  destination byte address, sampled on cfg_start
//  cfg_len      in   LEN_W   number of words, sampled on cfg_start
//  cfg_start    in   1       1-cycle start pulse
//  dma_busy     out  1       transfer in progress
//  dma_done     out  1       1-cycle pulse at transfer end
//  dma_err      out  1       sticky misalignment error, cleared by the next accepted cfg_start
//  mem_read     out  1       to DataMem read
//  mem_write    out  1       to DataMem write
//  mem_addr     out  ADDR_W  to DataMem address
//  mem_wdata    out  32      to DataMem wData
//  mem_rdata    in   32      from DataMem data (combinational, valid in the same cycle)
// BEHAVIOUR
//  Reset values:
//   - State IDLE; dma_busy=0, dma_done=0, dma_err=0, starve_cnt=0.
//   - The mem_* outputs pass the CPU signals through; cpu_stall=0.
//  FSM states: IDLE, RD, WR, FIN.
//   - IDLE: on cfg_start, latch src/dst/len and clear dma_err.
//     - If src[1:0]!=0 or dst[1:0]!=0: set dma_err and go to FIN.
//     - Else if len==0: go to FIN.
//     - Else go to RD.
//   - RD: on a granted cycle, mem_read=1, mem_addr=src, buf<=mem_rdata; src+=4; go to WR.
//   - WR: on a granted cycle, mem_write=1, mem_addr=dst, mem_wdata=buf; dst+=4, len-=1.
//     - If the decremented len==0, go to FIN; else go to RD.
//   - FIN: dma_done=1 for exactly one cycle; go to IDLE. dma_busy=1 in RD/WR/FIN.
//   - When a cycle is not granted, RD/WR hold state with no register change.
//  cfg_start outside IDLE is ignored; the latched config is unchanged.
//  Arbitration (combinational):
//   - dma_req = (state==RD or WR); cpu_req = cpu_read|cpu_write.
//   - dma_gnt = dma_req & (!cpu_req | starve_cnt==STARVE_LIMIT).
//   - cpu_stall = cpu_req & dma_gnt. When the CPU is granted, the mem_* outputs equal the cpu_* inputs.
//  starve_cnt:
//   - Increments when dma_req & !dma_gnt, saturating at STARVE_LIMIT.
//   - Clears on any dma_gnt or when !dma_req.
//  Latency:
//   - Uncontended N-word copy: start in cycle 0, first RD in cycle 1, last WR in cycle 2N, done pulse in cycle 2N+1.
//  Address arithmetic:
//   - Modulo 2^ADDR_W; wrap-around is not flagged.
//   - Overlapping src/dst is copied forward, word by word, with no hazard handling.
//  Reset mid-transfer:
//   - Go to IDLE immediately; no done pulse.
//   - Words already written remain in memory.
//   - A write in the same cycle as reset assertion must not occur (mem_write forced 0 while rst_n=0).
// STRUCTURE
//  Shared package mips_pkg: FSM state encoding (2 bits) and the word-stride constant (4).
//  One natural sub-module: mem_port_mux (grant-driven 2:1 mux of read/write/addr/wdata).
//  The FSM, counters and starvation counter stay in this module.
// TESTING
//  1. len=3, src=0x10, dst=0x40, CPU idle -> 0x40..0x48 equal 0x10..0x18; dma_done pulse in cycle 7; busy cycles 1-7.
//  2. cfg_len=0 -> dma_busy high for 1 cycle, dma_done in cycle 1, no mem_write asserted.
//  3. cfg_src=0x12 -> dma_err=1, dma_done in cycle 1, no memory access; the next valid start clears dma_err.
//  4. CPU lw every cycle, len=1, STARVE_LIMIT=4 -> cpu_stall in cycles 5 and 10 only; copy completes; CPU sees correct rdata when granted.
//  5. rst_n low during WR of word 2 of len=4 -> all outputs at reset values in the same cycle; no done; word 1 intact; word 2 dst unchanged.
//  6. cfg_start pulse while busy with different cfg values -> ignored; the original transfer completes with the original addresses.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory DMA/arbiter slice:
// DMA FSM state encoding and the word stride used for address stepping.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } dma_state_t;

    localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/mem_port_mux.sv
// Grant-driven 2:1 selection of the DataMem request signals between the CPU
// memory stage and the DMA engine.
module mem_port_mux #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              sel_dma,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              dma_read,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              mux_read,
    output logic              mux_write,
    output logic [ADDR_W-1:0] mux_addr,
    output logic [31:0]       mux_wdata
);

    always_comb begin
        if (sel_dma) begin
            mux_read  = dma_read;
            mux_write = dma_write;
            mux_addr  = dma_addr;
            mux_wdata = dma_wdata;
        end else begin
            mux_read  = cpu_read;
            mux_write = cpu_write;
            mux_addr  = cpu_addr;
            mux_wdata = cpu_wdata;
        end
    end

endmodule

// File: rtl/dma_mem_arbiter.sv
// Word-copy DMA engine sharing the single DataMem port with the CPU; the CPU
// has priority and the DMA gets a forced slot after STARVE_LIMIT denials.
module dma_mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_start,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              dma_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic [SW-1:0]     starve_q;

    logic              cfg_misaligned;
    logic              dma_req, cpu_req, dma_gnt;
    logic              dma_read, dma_write, mux_write;
    logic [ADDR_W-1:0] dma_addr;

    assign cfg_misaligned = (cfg_src[1:0] != 2'b00) || (cfg_dst[1:0] != 2'b00);
    assign cpu_req        = cpu_read | cpu_write;
    assign dma_gnt        = dma_req & (~cpu_req | (starve_q == SW'(STARVE_LIMIT)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cfg_start) state_d = (cfg_misaligned || cfg_len == '0) ? FIN : RD;
            RD:   if (dma_gnt) state_d = WR;
            WR:   if (dma_gnt) state_d = (len_q == LEN_W'(1)) ? FIN : RD;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dma_req   = (state_q == RD) || (state_q == WR);
        dma_read  = (state_q == RD);
        dma_write = (state_q == WR);
        dma_addr  = (state_q == RD) ? src_q : dst_q;
        dma_busy  = (state_q != IDLE);
        dma_done  = (state_q == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            if (state_q == IDLE && cfg_start) begin
                src_q <= cfg_src;
                dst_q <= cfg_dst;
                len_q <= cfg_len;
                err_q <= cfg_misaligned;
            end
            if (dma_gnt && state_q == RD) begin
                data_q <= mem_rdata;
                src_q  <= src_q + ADDR_W'(WORD_STRIDE);
            end
            if (dma_gnt && state_q == WR) begin
                dst_q <= dst_q + ADDR_W'(WORD_STRIDE);
                len_q <= len_q - LEN_W'(1);
            end
            if (!dma_req || dma_gnt)
                starve_q <= '0;
            else if (starve_q != SW'(STARVE_LIMIT))
                starve_q <= starve_q + SW'(1);
        end
    end

    mem_port_mux #(.ADDR_W(ADDR_W)) u_mux (
        .sel_dma   (dma_gnt),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dma_read  (dma_read),
        .dma_write (dma_write),
        .dma_addr  (dma_addr),
        .dma_wdata (data_q),
        .mux_read  (mem_read),
        .mux_write (mux_write),
        .mux_addr  (mem_addr),
        .mux_wdata (mem_wdata)
    );

    // Reset is asynchronous, so gate the write strobe directly to keep a
    // store from landing in the cycle reset is asserted.
    assign mem_write = mux_write & rst_n;
    assign cpu_stall = cpu_req & dma_gnt;
    assign cpu_rdata = mem_rdata;
    assign dma_err   = err_q;

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Randomised and directed bench for dma_mem_arbiter against a transaction-level
// model of the copy, the CPU-priority/starvation rule and the memory image.
module tb_dma_mem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = 16;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_read, cpu_write;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic [AW-1:0] cfg_src, cfg_dst;
    logic [LW-1:0] cfg_len;
    logic          cfg_start;
    logic          dma_busy, dma_done, dma_err;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dma_mem_arbiter #(.ADDR_W(AW), .LEN_W(LW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_start(cfg_start),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // 256-word DataMem model, aliased on address bits [9:2].
    logic [31:0] mem [0:255];
    logic [31:0] img [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    bit          prev_err = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                            input int unsigned pct, input bit ghost,
                            output int unsigned done_cyc, output int unsigned busy_cnt,
                            output int unsigned stall_cnt);
        bit          bad_al, fin, gnt, req;
        int unsigned ops, starve, k, budget, diffs, c;
        logic [31:0] a, b, rd_val;
        bad_al    = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        ops       = (bad_al || n == 0) ? 0 : 2 * n;
        fin       = (ops == 0);
        starve    = 0;
        rd_val    = '0;
        done_cyc  = 0;
        busy_cnt  = 0;
        stall_cnt = 0;
        for (int i = 0; i < 256; i++) img[i] = mem[i];
        if (ops != 0)
            for (int unsigned i = 0; i < n; i++) begin
                a = d + 4 * i;
                b = s + 4 * i;
                img[a[9:2]] = img[b[9:2]];
            end

        @(posedge clk); #1;
        cfg_src = s; cfg_dst = d; cfg_len = n[LW-1:0]; cfg_start = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        @(negedge clk);
        check_eq("c0_busy", dma_busy, 0);
        check_eq("c0_err", dma_err, prev_err);

        budget = (2 * n + 2) * (LIMIT + 1) + 8;
        for (c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            cfg_start = ghost && (c == 2);
            if (cfg_start) begin
                cfg_src = $urandom; cfg_dst = $urandom; cfg_len = LW'($urandom_range(1, 50));
            end
            cpu_read = ($urandom_range(99) < pct);
            cpu_addr = 32'($urandom_range(255)) << 2;
            @(negedge clk);
            req = cpu_read;
            gnt = (ops != 0) && (!req || starve == LIMIT);
            if (dma_busy)  busy_cnt++;
            if (cpu_stall) stall_cnt++;
            check_eq("busy", dma_busy, (ops != 0) || fin);
            check_eq("done", dma_done, fin);
            check_eq("err", dma_err, bad_al);
            check_eq("stall", cpu_stall, gnt && req);
            if (gnt) begin
                k = 2 * n - ops;
                a = (k % 2 == 0) ? s + 4 * (k / 2) : d + 4 * (k / 2);
                check_eq("dma_addr", mem_addr, a);
                check_eq("dma_rd", mem_read, k % 2 == 0);
                check_eq("dma_wr", mem_write, k % 2 == 1);
                if (k % 2 == 0) rd_val = mem[a[9:2]];
                else            check_eq("dma_wdata", mem_wdata, rd_val);
            end else begin
                check_eq("cpu_addr", mem_addr, cpu_addr);
                check_eq("cpu_rd", mem_read, req);
                check_eq("cpu_wr", mem_write, 0);
                if (req) check_eq("cpu_rdata", cpu_rdata, mem[cpu_addr[9:2]]);
            end
            if (fin) begin
                done_cyc = c;
                break;
            end
            if (gnt) begin
                ops--;
                starve = 0;
                if (ops == 0) fin = 1'b1;
            end else if (ops != 0 && starve < LIMIT) begin
                starve++;
            end
        end
        cfg_start = 1'b0;
        cpu_read  = 1'b0;
        check_eq("done_seen", done_cyc != 0, 1);
        prev_err = bad_al;
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) diffs++;
        check_eq("image", diffs, 0);
    endtask

    int unsigned dc, bc, sc, pct;
    logic [31:0] rs, rd, w_src0, w_dst1, w_src1;

    initial begin
        rst_n = 1'b0;
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hDEAD_BEEF;
        cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #3;
        check_eq("rst_busy", dma_busy, 0);
        check_eq("rst_done", dma_done, 0);
        check_eq("rst_err", dma_err, 0);
        check_eq("rst_stall", cpu_stall, 0);
        check_eq("rst_wr_gated", mem_write, 0);
        check_eq("rst_rd_pass", mem_read, 1);
        check_eq("rst_addr_pass", mem_addr, 32'h44);
        check_eq("rst_wdata_pass", mem_wdata, 32'hDEAD_BEEF);
        cpu_read = 1'b0; cpu_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Uncontended 3-word copy: done in cycle 7, busy cycles 1..7.
        run_xfer(32'h10, 32'h40, 3, 0, 1'b0, dc, bc, sc);
        check_eq("t1_done_cyc", dc, 7);
        check_eq("t1_busy_cnt", bc, 7);

        run_xfer(32'h20, 32'h60, 0, 0, 1'b0, dc, bc, sc);
        check_eq("t2_done_cyc", dc, 1);
        check_eq("t2_busy_cnt", bc, 1);

        run_xfer(32'h12, 32'h80, 2, 0, 1'b0, dc, bc, sc);
        check_eq("t3_done_cyc", dc, 1);
        run_xfer(32'h20, 32'h80, 2, 0, 1'b0, dc, bc, sc);
        check_eq("t3_clear_done", dc, 5);

        // CPU reads every cycle: forced DMA slots in cycles 5 and 10.
        run_xfer(32'h30, 32'hA0, 1, 100, 1'b0, dc, bc, sc);
        check_eq("t4_done_cyc", dc, 11);
        check_eq("t4_stall_cnt", sc, 2);

        run_xfer(32'h30, 32'h90, 3, 0, 1'b1, dc, bc, sc);
        check_eq("t6_done_cyc", dc, 7);

        // Reset while the DMA is writing word 2 of a 4-word copy.
        w_src0 = mem[32'h100 >> 2];
        w_src1 = mem[32'h104 >> 2];
        w_dst1 = mem[32'h204 >> 2];
        @(posedge clk); #1;
        cfg_src = 32'h100; cfg_dst = 32'h200; cfg_len = 16'd4; cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_in_wr", mem_write, 1);
        check_eq("t5_wr_addr", mem_addr, 32'h204);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t5_busy", dma_busy, 0);
        check_eq("t5_done", dma_done, 0);
        check_eq("t5_err", dma_err, 0);
        check_eq("t5_wr", mem_write, 0);
        check_eq("t5_rd", mem_read, 0);
        check_eq("t5_stall", cpu_stall, 0);
        check_eq("t5_addr", mem_addr, cpu_addr);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t5_no_done", dma_done, 0);
            check_eq("t5_idle", dma_busy, 0);
        end
        check_eq("t5_word1", mem[32'h200 >> 2], w_src0);
        check_eq("t5_word2", mem[32'h204 >> 2], w_dst1);
        check_eq("t5_src2", mem[32'h104 >> 2], w_src1);
        prev_err = 1'b0;

        for (int t = 0; t < 40; t++) begin
            rs = 32'($urandom_range(255)) << 2;
            rd = 32'($urandom_range(255)) << 2;
            if ($urandom_range(7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(7) == 0) rd[1:0] = 2'($urandom_range(1, 3));
            case ($urandom_range(3))
                0: pct = 0;
                1: pct = 30;
                2: pct = 70;
                default: pct = 100;
            endcase
            run_xfer(rs, rd, $urandom_range(8), pct, $urandom_range(3) == 0, dc, bc, sc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
